// File: rtl/fetch_mem_unit.sv
// rtl/fetch_mem_unit.sv - PC/IR/MDR owner and shared memory port sequencer for the multicycle MIPS core
module fetch_mem_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          TIMEOUT  = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        pcwrite,
  input  logic        branch,
  input  logic        zero,
  input  logic [1:0]  pcsrc,
  input  logic        irwrite,
  input  logic        iord,
  input  logic        mem_rd,
  input  logic        memwrite,
  input  logic [31:0] aluresult,
  input  logic [31:0] aluout,
  input  logic [31:0] wdata,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic        mem_ready,
  input  logic [31:0] mem_rdata,
  output logic        stall,
  output logic [31:0] pc,
  output logic [31:0] instr,
  output logic [31:0] mdr,
  output logic        bus_err
);

  localparam int CW = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t        state, state_nxt;
  logic [CW-1:0] tcnt;
  logic [31:0]   addr_q, wdata_q, rdata_q;
  logic          we_q;
  logic [31:0]   req_addr, pc_nxt;
  logic          req, misaligned, timeout_hit;
  logic          latch, capture, err_set, pcen;

  assign req         = mem_rd | memwrite;
  assign req_addr    = iord ? aluout : pc;
  assign misaligned  = (req_addr[1:0] != 2'b00);
  assign timeout_hit = (tcnt == CW'(TIMEOUT - 1));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    stall     = 1'b0;
    mem_req   = 1'b0;
    mem_we    = 1'b0;
    latch     = 1'b0;
    capture   = 1'b0;
    err_set   = 1'b0;
    case (state)
      IDLE: begin
        if (req) begin
          stall   = 1'b1;
          latch   = 1'b1;
          // a simultaneous read+write proceeds as a write but is still an error
          err_set = misaligned | (mem_rd & memwrite);
          state_nxt = misaligned ? DONE : BUSY;
        end
      end
      BUSY: begin
        stall   = 1'b1;
        mem_req = 1'b1;
        mem_we  = we_q;
        if (mem_ready) begin
          capture   = 1'b1;
          state_nxt = DONE;
        end else if (timeout_hit) begin
          err_set   = 1'b1;
          state_nxt = DONE;
        end
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    pc_nxt = pc;
    case (pcsrc)
      2'b00:   pc_nxt = aluresult;
      2'b01:   pc_nxt = aluout;
      2'b10:   pc_nxt = {pc[31:28], instr[25:0], 2'b00};
      default: pc_nxt = pc;
    endcase
  end

  assign pcen      = (pcwrite | (branch & zero)) & ~stall & (pcsrc != 2'b11);
  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc      <= RESET_PC;
      instr   <= 32'h0;
      mdr     <= 32'h0;
      bus_err <= 1'b0;
      addr_q  <= 32'h0;
      wdata_q <= 32'h0;
      rdata_q <= 32'h0;
      we_q    <= 1'b0;
      tcnt    <= '0;
    end else begin
      // rdata_q clears on every new access so error paths deliver zero
      if (latch) begin
        addr_q  <= req_addr;
        wdata_q <= wdata;
        we_q    <= memwrite;
        rdata_q <= 32'h0;
        tcnt    <= '0;
      end
      if (state == BUSY && !mem_ready)
        tcnt <= tcnt + CW'(1);
      if (capture && !we_q)
        rdata_q <= mem_rdata;
      if (err_set)
        bus_err <= 1'b1;
      if (state == DONE && !we_q) begin
        mdr <= rdata_q;
        if (irwrite && !stall)
          instr <= rdata_q;
      end
      if (pcen)
        pc <= pc_nxt;
    end
  end

endmodule

// File: tb/tb_fetch_mem_unit.sv
// tb/tb_fetch_mem_unit.sv - self-checking bench for fetch_mem_unit against a transaction-level model
module tb_fetch_mem_unit;

  localparam logic [31:0] RP = 32'h0000_0000;
  localparam int          TO = 16;

  logic        clk = 1'b0;
  logic        reset;
  logic        pcwrite, branch, zero, irwrite, iord, mem_rd, memwrite, mem_ready;
  logic [1:0]  pcsrc;
  logic [31:0] aluresult, aluout, wdata, mem_rdata;
  logic        mem_req, mem_we, stall, bus_err;
  logic [31:0] mem_addr, mem_wdata, pc, instr, mdr;

  int checks   = 0;
  int failures = 0;

  logic [31:0] pc_m, instr_m, mdr_m;
  logic        err_m;

  fetch_mem_unit #(.RESET_PC(RP), .TIMEOUT(TO)) dut (
    .clk(clk), .reset(reset), .pcwrite(pcwrite), .branch(branch), .zero(zero),
    .pcsrc(pcsrc), .irwrite(irwrite), .iord(iord), .mem_rd(mem_rd), .memwrite(memwrite),
    .aluresult(aluresult), .aluout(aluout), .wdata(wdata), .mem_req(mem_req),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_ready(mem_ready),
    .mem_rdata(mem_rdata), .stall(stall), .pc(pc), .instr(instr), .mdr(mdr),
    .bus_err(bus_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic clear_inputs();
    pcwrite = 0; branch = 0; zero = 0; pcsrc = 2'b00; irwrite = 0; iord = 0;
    mem_rd = 0; memwrite = 0; mem_ready = 0;
  endtask

  task automatic check_regs(input string tag);
    chk({tag, ".pc"}, pc, pc_m);
    chk({tag, ".instr"}, instr, instr_m);
    chk({tag, ".mdr"}, mdr, mdr_m);
    chk({tag, ".bus_err"}, {31'b0, bus_err}, {31'b0, err_m});
  endtask

  task automatic model_reset();
    pc_m = RP; instr_m = 32'h0; mdr_m = 32'h0; err_m = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    clear_inputs();
    reset = 1;
    model_reset();
    #1;
    check_regs("reset");
    chk("reset.stall", {31'b0, stall}, 32'h0);
    chk("reset.mem_req", {31'b0, mem_req}, 32'h0);
    @(negedge clk);
    reset = 0;
  endtask

  // architectural PC update from the decoder's point of view
  function automatic logic [31:0] next_pc(input logic pcw, br, z, input logic [1:0] ps,
                                          input logic [31:0] aout, ares, cur_pc, cur_ir);
    if (!(pcw || (br && z)) || ps == 2'b11) return cur_pc;
    if (ps == 2'b00) return ares;
    if (ps == 2'b01) return aout;
    return {cur_pc[31:28], cur_ir[25:0], 2'b00};
  endfunction

  // one decoder memory state held until the unit releases stall; memory answers after 'delay' waits
  task automatic do_access(input logic rd, wr, io, irw, pcw, br, z, input logic [1:0] ps,
                           input logic [31:0] aout, ares, wd, rdat, input int delay);
    logic [31:0] addr, data, pc_new;
    logic        misal, tmo, err;
    int          busy, nstall;
    addr   = io ? aout : pc_m;
    misal  = (addr[1:0] != 2'b00);
    tmo    = !misal && (delay >= TO);
    busy   = misal ? 0 : (tmo ? TO : delay + 1);
    nstall = 1 + busy;
    @(negedge clk);
    mem_rd = rd; memwrite = wr; iord = io; irwrite = irw; pcwrite = pcw;
    branch = br; zero = z; pcsrc = ps; aluout = aout; aluresult = ares; wdata = wd;
    mem_ready = 0;
    for (int c = 0; c <= nstall; c++) begin
      if (c > 0) @(negedge clk);
      #1;
      chk($sformatf("acc.stall[%0d]", c), {31'b0, stall}, {31'b0, c < nstall});
      chk($sformatf("acc.mem_req[%0d]", c), {31'b0, mem_req}, {31'b0, c >= 1 && c <= busy});
      if (c >= 1 && c <= busy) begin
        chk("acc.mem_addr", mem_addr, addr);
        chk("acc.mem_we", {31'b0, mem_we}, {31'b0, wr});
        if (wr) chk("acc.mem_wdata", mem_wdata, wd);
      end
      chk("acc.pc_hold", pc, pc_m);
      mem_ready = (c >= 1 && c == busy && !tmo);
      mem_rdata = rdat;
    end
    @(posedge clk);
    #1;
    clear_inputs();
    err    = misal || tmo || (rd && wr);
    data   = (misal || tmo) ? 32'h0 : rdat;
    pc_new = next_pc(pcw, br, z, ps, aout, ares, pc_m, instr_m);
    if (!wr) begin
      mdr_m = data;
      if (irw) instr_m = data;
    end
    pc_m  = pc_new;
    err_m = err_m | err;
    check_regs("acc");
    chk("acc.idle_req", {31'b0, mem_req}, 32'h0);
  endtask

  // PC-only decoder state, no memory traffic
  task automatic pc_op(input logic pcw, br, z, input logic [1:0] ps, input logic [31:0] aout, ares);
    @(negedge clk);
    pcwrite = pcw; branch = br; zero = z; pcsrc = ps; aluout = aout; aluresult = ares;
    #1;
    chk("pcop.stall", {31'b0, stall}, 32'h0);
    @(posedge clk);
    #1;
    clear_inputs();
    pc_m = next_pc(pcw, br, z, ps, aout, ares, pc_m, instr_m);
    chk("pcop.pc", pc, pc_m);
  endtask

  task automatic rand_access(input bit allow_err);
    logic rd, wr;
    logic [31:0] aout;
    wr   = 1'($urandom_range(0, 1));
    rd   = !wr;
    if (allow_err && $urandom_range(0, 5) == 0) rd = 1;
    aout = $urandom & 32'hFFFF_FFFC;
    if (allow_err && $urandom_range(0, 5) == 0) aout[1:0] = 2'($urandom_range(1, 3));
    do_access(rd, wr, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
              1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
              2'($urandom_range(0, 3)), aout, $urandom & 32'hFFFF_FFFC, $urandom, $urandom,
              allow_err ? int'($urandom_range(0, TO + 2)) : int'($urandom_range(0, 6)));
  endtask

  initial begin
    clear_inputs();
    aluresult = 0; aluout = 0; wdata = 0; mem_rdata = 0;
    reset = 1;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_regs("por");
    chk("por.mem_req", {31'b0, mem_req}, 32'h0);
    chk("por.mem_we", {31'b0, mem_we}, 32'h0);
    chk("por.stall", {31'b0, stall}, 32'h0);
    @(negedge clk);
    reset = 0;

    // fetch from a single-wait memory, then a slow one
    do_access(1, 0, 0, 1, 1, 0, 0, 2'b00, 32'h0, 32'h4, 32'h0, 32'h8C08_0004, 0);
    chk("fetch.instr", instr, 32'h8C08_0004);
    chk("fetch.pc", pc, 32'h4);
    do_access(1, 0, 0, 1, 1, 0, 0, 2'b00, 32'h0, 32'h8, 32'h0, 32'h1234_5678, 4);

    // store: mdr keeps the last read value
    do_access(0, 1, 1, 0, 0, 0, 0, 2'b00, 32'h100, 32'h0, 32'hDEAD_BEEF, 32'h5555_AAAA, 1);
    chk("store.mdr", mdr, 32'h1234_5678);

    // branches and jump
    pc_op(0, 1, 0, 2'b01, 32'h40, 32'h0);
    pc_op(0, 1, 1, 2'b01, 32'h40, 32'h0);
    chk("branch.pc", pc, 32'h40);
    pc_op(1, 0, 0, 2'b11, 32'h80, 32'h84);
    pc_op(1, 0, 0, 2'b00, 32'h0, 32'h1000_0008);
    do_access(1, 0, 0, 1, 0, 0, 0, 2'b00, 32'h0, 32'h0, 32'h0, 32'h0800_0010, 2);
    pc_op(1, 0, 0, 2'b10, 32'h0, 32'h0);
    chk("jump.pc", pc, 32'h1000_0040);

    for (int i = 0; i < 20; i++) rand_access(0);

    // timeout: sticky error and zeroed read data
    do_access(1, 0, 0, 0, 0, 0, 0, 2'b00, 32'h0, 32'h0, 32'h0, 32'hFFFF_FFFF, TO + 3);
    chk("timeout.mdr", mdr, 32'h0);
    do_access(1, 0, 1, 0, 0, 0, 0, 2'b00, 32'h200, 32'h0, 32'h0, 32'h0BAD_F00D, 15);
    chk("timeout.sticky", {31'b0, bus_err}, 32'h1);

    do_reset();
    do_access(0, 1, 1, 0, 0, 0, 0, 2'b00, 32'h102, 32'h0, 32'hDEAD_BEEF, 32'h0, 0);
    chk("misaligned.bus_err", {31'b0, bus_err}, 32'h1);

    do_reset();
    do_access(1, 1, 1, 1, 0, 0, 0, 2'b00, 32'h300, 32'h0, 32'hCAFE_0001, 32'h7777_7777, 0);
    chk("both.bus_err", {31'b0, bus_err}, 32'h1);

    // reset in the middle of an access, then a stray ready
    do_reset();
    do_access(1, 0, 0, 1, 1, 0, 0, 2'b00, 32'h0, 32'h20, 32'h0, 32'h1357_9BDF, 0);
    @(negedge clk);
    mem_rd = 1; iord = 0;
    repeat (3) @(negedge clk);
    #1;
    chk("midrst.busy", {31'b0, mem_req}, 32'h1);
    reset = 1;
    clear_inputs();
    model_reset();
    #1;
    chk("midrst.mem_req", {31'b0, mem_req}, 32'h0);
    chk("midrst.stall", {31'b0, stall}, 32'h0);
    check_regs("midrst");
    @(negedge clk);
    reset = 0;
    mem_ready = 1;
    mem_rdata = 32'hFACE_FACE;
    repeat (3) @(negedge clk);
    #1;
    chk("stray.mem_req", {31'b0, mem_req}, 32'h0);
    chk("stray.stall", {31'b0, stall}, 32'h0);
    check_regs("stray");
    mem_ready = 0;

    for (int i = 0; i < 15; i++) rand_access(1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/fetch_mem_unit.md
Name: fetch_mem_unit

Overview:
- Owns the architectural PC, the instruction register (IR) and the memory data register (MDR) of the multicycle MIPS core.
- Drives the single shared instruction/data memory port through a req/ready handshake.
- Consumes the main decoder's control outputs and feeds the opcode back to it.
- Asserts stall while a memory access is outstanding, so the decoder FSM holds its state.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset.
- TIMEOUT, 16, max cycles waiting for mem_ready before a bus error is flagged (≥2).

Ports:
- clk  in  1  clock
- reset  in  1  async active-high reset
- pcwrite  in  1  unconditional PC update (from main decoder)
- branch  in  1  conditional PC update when zero=1
- zero  in  1  ALU zero flag
- pcsrc  in  2  PC source: 00 aluresult, 01 aluout, 10 jump target, 11 reserved (no update)
- irwrite  in  1  load IR from returned read data
- iord  in  1  address select: 0 PC, 1 aluout
- mem_rd  in  1  decoder requests a memory read this state
- memwrite  in  1  decoder requests a memory write this state
- aluresult  in  32  combinational ALU result
- aluout  in  32  registered ALU result
- wdata  in  32  store data (rt register value)
- mem_req  out  1  memory request valid
- mem_we  out  1  write enable qualifying mem_req
- mem_addr  out  32  word address (byte address, [1:0]=00)
- mem_wdata  out  32  write data
- mem_ready  in  1  memory accepted/completed the request this cycle
- mem_rdata  in  32  read data, valid when mem_ready=1 and mem_we=0
- stall  out  1  hold decoder state and all other architectural writes
- pc  out  32  current PC
- instr  out  32  IR contents; op = instr[31:26]
- mdr  out  32  memory data register
- bus_err  out  1  sticky: timeout or misaligned access

Behaviour:
- Reset (async, any state, mid-access included):
  - pc=RESET_PC, instr=0, mdr=0, bus_err=0.
  - FSM returns to IDLE, mem_req=0, mem_we=0, stall=0.
  - An in-flight access is abandoned; a late mem_ready after reset is ignored, because IDLE does not sample it.
- FSM states:
  - IDLE: on (mem_rd|memwrite) go to BUSY. The address is latched from iord ? aluout : pc, along with mem_we=memwrite and mem_wdata=wdata. Addr/wdata/we are registered, so mem_req rises the cycle after the decoder asserts the request.
  - BUSY: mem_req=1, stall=1. On mem_ready → DONE, capturing mem_rdata for reads. A timeout counter increments each BUSY cycle; at TIMEOUT without ready → DONE with bus_err set and read data forced to 0.
  - DONE: stall=0 for exactly one cycle, during which the decoder advances. IR/MDR writes and the PC update occur at the end of this cycle. Next state is IDLE.
- Stall timing: stall=1 in the IDLE cycle where a new request is seen, and throughout BUSY. Minimum access latency is therefore 3 cycles (IDLE-req, BUSY-ready, DONE).
- mem_rd and memwrite both high: treated as a write; bus_err is set.
- Misaligned address (latched address[1:0]≠00): no mem_req is issued. FSM goes directly to DONE, bus_err is set, and read data is 0.
- PC update:
  - Enable pcen = (pcwrite | (branch & zero)) & ~stall.
  - Source: pcsrc 00 → aluresult, 01 → aluout, 10 → {pc[31:28], instr[25:0], 2'b00}.
  - pcsrc 11 suppresses the update.
  - The jump target uses the PC value before this update.
- IR load: irwrite & ~stall & read completed in DONE. mdr loads on every completed read. Writes leave instr/mdr unchanged.
- A PC update and an IR load in the same DONE cycle (fetch state) are legal and both occur.
- bus_err is cleared only by reset.
- All arithmetic is 32-bit; no PC increment is done internally (the ALU supplies PC+4).

Test Plan:
- Fetch, 1-cycle-ready memory: mem_rd=1, irwrite=1, pcwrite=1, pcsrc=00, aluresult=4, pc=0 → mem_addr=0; stall for 2 cycles; instr=mem_rdata (0x8C08_0004), pc=4 after DONE.
- Slow memory: mem_ready delayed 5 cycles → stall held 6 cycles, mem_req stable with constant addr; no PC/IR change until DONE.
- Timeout: mem_ready never asserted, TIMEOUT=16 → DONE after 16 BUSY cycles, bus_err=1, mdr=0, bus_err persists until reset.
- Store with iord=1, aluout=0x100, wdata=0xDEAD_BEEF → mem_we=1, mem_addr=0x100, mem_wdata=0xDEAD_BEEF; mdr unchanged. Then aluout=0x102 → no mem_req, bus_err=1.
- Branch/jump: branch=1, zero=0 → pc unchanged; zero=1, pcsrc=01, aluout=0x40 → pc=0x40. pcwrite=1, pcsrc=10, pc=0x1000_0008, instr[25:0]=0x000_0010 → pc=0x1000_0040.
- Reset asserted in BUSY mid-access → mem_req=0, stall=0, pc=RESET_PC immediately; a subsequent stray mem_ready causes no state change.
